// File: rtl/debug_ctrl.sv
// Debug sequencer between board I/O and the CPU: turns a synchronized button strobe plus a
// switch word into run/pause, single-step and register/memory read-out operations.
module debug_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int RF_LAT  = 0,
    parameter int MEM_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       data,
    input  logic              en,
    input  logic [31:0]       rf_rdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_en,
    output logic [4:0]        rf_raddr,
    output logic [MEM_AW-1:0] mem_raddr,
    output logic              dbg_mem_sel,
    output logic [15:0]       result,
    output logic              busy,
    output logic              running
);

    // Handshake: en is a raw level; cmd_go is a one-cycle pulse on its synchronized rising
    // edge and is acted on only in IDLE or RUN, otherwise it is dropped.
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_STEP, S_RD_ADDR, S_RD_WAIT, S_RD_CAP
    } state_t;

    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b11;
    localparam logic [2:0] MEM_L3  = 3'(MEM_LAT);
    localparam logic [2:0] RF_L3   = 3'(RF_LAT);

    state_t     state;
    logic [2:0] en_sync;
    logic [2:0] cmd_reg;
    logic       resume;
    logic [2:0] cnt;

    logic       cmd_go;
    logic [1:0] new_op;
    logic       cur_mem;
    logic [2:0] cur_lat;
    logic [31:0] rdata;
    logic [15:0] rhalf;
    logic       unused_bits;

    assign cmd_go  = en_sync[1] & ~en_sync[2];
    assign new_op  = data[15:14];
    assign cur_mem = (cmd_reg[2:1] == OP_MEM);
    assign cur_lat = cur_mem ? MEM_L3 : RF_L3;
    assign rdata   = cur_mem ? mem_rdata : rf_rdata;
    assign rhalf   = cmd_reg[0] ? rdata[31:16] : rdata[15:0];
    assign unused_bits = ^data[12:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync <= 3'b000;
        end else begin
            en_sync <= {en_sync[1:0], en};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_reg     <= 3'b000;
            resume      <= 1'b0;
            cnt         <= 3'd0;
            cpu_en      <= 1'b0;
            dbg_mem_sel <= 1'b0;
            rf_raddr    <= 5'd0;
            mem_raddr   <= '0;
            result      <= 16'h0000;
            busy        <= 1'b0;
            running     <= 1'b0;
        end else if (cmd_go && new_op[1] && (state == S_IDLE || state == S_RUN)) begin
            // Read start: cpu_en falls on the same edge dbg_mem_sel rises, so the two never overlap.
            cmd_reg     <= data[15:13];
            resume      <= (state == S_RUN);
            state       <= S_RD_ADDR;
            cpu_en      <= 1'b0;
            running     <= 1'b0;
            busy        <= 1'b1;
            dbg_mem_sel <= (new_op == OP_MEM);
            if (new_op == OP_MEM) begin
                mem_raddr <= data[MEM_AW-1:0];
            end else begin
                rf_raddr <= data[4:0];
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_go) begin
                        cmd_reg <= data[15:13];
                        if (new_op == OP_STEP) begin
                            state  <= S_STEP;
                            cpu_en <= 1'b1;
                            busy   <= 1'b1;
                        end else if (new_op == OP_RUN) begin
                            state   <= S_RUN;
                            cpu_en  <= 1'b1;
                            running <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Both STEP and the toggle pause a running CPU.
                    if (cmd_go) begin
                        cmd_reg <= data[15:13];
                        state   <= S_IDLE;
                        cpu_en  <= 1'b0;
                        running <= 1'b0;
                    end
                end
                S_STEP: begin
                    state  <= S_IDLE;
                    cpu_en <= 1'b0;
                    busy   <= 1'b0;
                end
                S_RD_ADDR: begin
                    if (cur_lat == 3'd0) begin
                        result <= rhalf;
                        state  <= S_RD_CAP;
                    end else begin
                        cnt   <= cur_lat - 3'd1;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        result <= rhalf;
                        state  <= S_RD_CAP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RD_CAP: begin
                    dbg_mem_sel <= 1'b0;
                    busy        <= 1'b0;
                    if (resume) begin
                        state   <= S_RUN;
                        cpu_en  <= 1'b1;
                        running <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cpu_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: directed timing scenarios plus random commands checked against a
// command-level model of run state, expected read results and cpu_en/dbg_mem_sel activity.
module tb_debug_ctrl;

    localparam int MEM_LAT = 1;
    localparam int RF_LAT  = 0;
    localparam int MEM_AW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       data = 16'h0000;
    logic              en = 1'b0;
    logic [31:0]       rf_rdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              cpu_en;
    logic [4:0]        rf_raddr;
    logic [MEM_AW-1:0] mem_raddr;
    logic              dbg_mem_sel;
    logic [15:0]       result;
    logic              busy;
    logic              running;

    logic [31:0] rf_arr [32];
    logic [31:0] mem_arr [2**MEM_AW];

    int checks = 0;
    int failures = 0;
    int rises = 0;
    int sel_cycles = 0;
    int overlaps = 0;
    logic prev_cpu_en = 1'b0;

    logic        m_running = 1'b0;
    logic [15:0] m_result = 16'h0000;
    logic [15:0] exp_q [$];

    debug_ctrl #(.MEM_LAT(MEM_LAT), .RF_LAT(RF_LAT), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .data(data), .en(en),
        .rf_rdata(rf_rdata), .mem_rdata(mem_rdata),
        .cpu_en(cpu_en), .rf_raddr(rf_raddr), .mem_raddr(mem_raddr),
        .dbg_mem_sel(dbg_mem_sel), .result(result), .busy(busy), .running(running)
    );

    // Clock and memory models: register file is combinational, data memory has one cycle of latency.
    always #5 clk = ~clk;
    assign rf_rdata = rf_arr[rf_raddr];
    always @(posedge clk) mem_rdata <= mem_arr[mem_raddr];

    always @(negedge clk) begin
        if (rst) begin
            prev_cpu_en = 1'b0;
        end else begin
            if (cpu_en && !prev_cpu_en) rises++;
            if (dbg_mem_sel) sel_cycles++;
            if (cpu_en && dbg_mem_sel) overlaps++;
            prev_cpu_en = cpu_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        data = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_running = 1'b0;
        m_result = 16'h0000;
    endtask

    function automatic logic [15:0] read_half(input logic [15:0] d);
        logic [31:0] w;
        w = (d[15:14] == 2'b11) ? mem_arr[d[MEM_AW-1:0]] : rf_arr[d[4:0]];
        return d[13] ? w[31:16] : w[15:0];
    endfunction

    // Command-level model: returns expected cpu_en rises and debug-ownership cycles.
    task automatic model_cmd(input logic [15:0] d, output int exp_rises, output int exp_sel);
        exp_rises = 0;
        exp_sel = 0;
        case (d[15:14])
            2'b00: begin
                exp_rises = m_running ? 0 : 1;
                m_running = 1'b0;
            end
            2'b01: begin
                exp_rises = m_running ? 0 : 1;
                m_running = !m_running;
            end
            default: begin
                exp_rises = m_running ? 1 : 0;
                exp_sel = (d[15:14] == 2'b11) ? 2 + MEM_LAT : 0;
                m_result = read_half(d);
            end
        endcase
        exp_q.push_back(m_result);
    endtask

    task automatic run_cmd(input logic [15:0] d, input int hold);
        int exp_rises;
        int exp_sel;
        logic [15:0] exp_res;
        model_cmd(d, exp_rises, exp_sel);
        @(negedge clk);
        data = d;
        en = 1'b1;
        rises = 0;
        sel_cycles = 0;
        overlaps = 0;
        repeat (hold) @(negedge clk);
        en = 1'b0;
        repeat (16 - hold) @(negedge clk);
        exp_res = exp_q.pop_front();
        check("cmd_result", result, exp_res);
        check("cmd_running", running, m_running);
        check("cmd_cpu_en", cpu_en, m_running);
        check("cmd_busy", busy, 1'b0);
        check("cmd_sel_idle", dbg_mem_sel, 1'b0);
        check("cmd_rises", rises, exp_rises);
        check("cmd_sel_cycles", sel_cycles, exp_sel);
        check("cmd_overlap", overlaps, 0);
        if (d[15:14] == 2'b10) check("cmd_rf_addr", rf_raddr, d[4:0]);
        if (d[15:14] == 2'b11) check("cmd_mem_addr", mem_raddr, d[MEM_AW-1:0]);
    endtask

    // Cycle-accurate read: k counts clock edges after en rises.
    task automatic timed_read(input logic [15:0] d);
        logic [15:0] old_res;
        logic [15:0] new_res;
        logic        was_running;
        int          lat;
        logic        in_win;
        old_res = m_result;
        new_res = read_half(d);
        was_running = m_running;
        lat = (d[15:14] == 2'b11) ? MEM_LAT : RF_LAT;
        m_result = new_res;
        @(negedge clk);
        data = d;
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 2) en = 1'b0;
            in_win = (k >= 3) && (k <= 4 + lat);
            check("rd_result", result, (k >= 4 + lat) ? new_res : old_res);
            check("rd_sel", dbg_mem_sel, in_win && (d[15:14] == 2'b11));
            check("rd_cpu_en", cpu_en, was_running && !in_win);
            check("rd_busy", busy, in_win);
        end
    endtask

    initial begin
        logic [15:0] d;
        for (int i = 0; i < 32; i++) rf_arr[i] = $urandom;
        for (int i = 0; i < 2**MEM_AW; i++) mem_arr[i] = $urandom;
        rf_arr[5] = 32'hBEEF_0005;
        mem_arr[10] = 32'h1234_5678;
        mem_arr[20] = 32'hCAFE_0001;

        // Reset then idle
        do_reset();
        rises = 0;
        sel_cycles = 0;
        repeat (20) @(negedge clk);
        check("idle_rises", rises, 0);
        check("idle_sel_cycles", sel_cycles, 0);
        check("idle_cpu_en", cpu_en, 1'b0);
        check("idle_result", result, 16'h0000);
        check("idle_running", running, 1'b0);
        check("idle_sel", dbg_mem_sel, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Single step with en held for 10 cycles
        data = 16'h0000;
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 10) en = 1'b0;
            check("step_cpu_en", cpu_en, k == 3);
        end

        // Run/pause toggle
        run_cmd(16'h4000, 2);
        check("run_running", running, 1'b1);
        run_cmd(16'h4000, 2);
        check("pause_cpu_en", cpu_en, 1'b0);

        // Register-file reads, both halves
        run_cmd(16'h8005, 3);
        check("rf_low_lit", result, 16'h0005);
        timed_read(16'hA005);
        check("rf_high_lit", result, 16'hBEEF);

        // Memory read while running
        run_cmd(16'h4000, 1);
        timed_read(16'hC00A);
        check("mem_lit", result, 16'h5678);
        repeat (3) @(negedge clk);
        check("mem_resume", cpu_en, 1'b1);

        // A second strobe during RD_WAIT is dropped
        rises = 0;
        sel_cycles = 0;
        overlaps = 0;
        data = 16'hE014;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        data = 16'hC00A;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (12) @(negedge clk);
        m_result = 16'hCAFE;
        check("drop_result", result, 16'hCAFE);
        check("drop_mem_addr", mem_raddr, 8'd20);
        check("drop_sel_cycles", sel_cycles, 2 + MEM_LAT);
        check("drop_overlap", overlaps, 0);
        check("drop_running", running, 1'b1);

        // Asynchronous reset in the middle of a read
        data = 16'hC00A;
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) en = 1'b0;
        end
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_cpu_en", cpu_en, 1'b0);
        check("rst_sel", dbg_mem_sel, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_rf_addr", rf_raddr, 5'd0);
        check("rst_mem_addr", mem_raddr, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        m_running = 1'b0;
        m_result = 16'h0000;
        check("post_rst_running", running, 1'b0);
        check("post_rst_cpu_en", cpu_en, 1'b0);
        check("post_rst_result", result, 16'h0000);

        // Random commands against the model
        for (int n = 0; n < 40; n++) begin
            d = {2'($urandom_range(0, 3)), 1'($urandom), 13'($urandom)};
            run_cmd(d, $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_ctrl.md
Name: debug_ctrl

Overview:
Sequences the CPU debug path. It converts a button-level enable (en) plus a 16-bit switch word (data) into run, pause, single-step and register/memory read-out operations. It gates the CPU clock enable and borrows the shared data-memory read port from the CPU for debug reads. The returned word is presented on a 16-bit result display bus. It sits between the board I/O and the CPU core/memory.

Parameters:
MEM_LAT, 1, cycles from mem_raddr valid to mem_rdata valid (1..4)
RF_LAT, 0, cycles from rf_raddr valid to rf_rdata valid (0..4)
MEM_AW, 8, debug memory word-address width (≤13)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
data  in  16  command word: [15:14] op, [13] half select, [12:0] address field
en  in  1  command strobe, level from button, asynchronous to clk
rf_rdata  in  32  register-file debug read data
mem_rdata  in  32  data-memory read data (shared port)
cpu_en  out  1  CPU clock enable; CPU state advances only when 1
rf_raddr  out  5  register-file debug read address
mem_raddr  out  MEM_AW  debug memory word address
dbg_mem_sel  out  1  1 = memory read port owned by debug, 0 = CPU
result  out  16  last captured read half-word
busy  out  1  1 while a read or step is in progress
running  out  1  1 in RUN state

Behaviour:
- Reset (async, any state): state=IDLE; cpu_en=0, dbg_mem_sel=0, rf_raddr=0, mem_raddr=0, result=0, busy=0, running=0; synchronizer flops cleared.
- en passes through a 2-flop synchronizer and a rising-edge detector. A pulse cmd_go lasts exactly 1 cycle, 3 clk edges after en first samples high. Holding en high gives one command only.
- data is sampled into cmd_reg on the cmd_go cycle. Later changes to data do not affect an in-flight op.
- Ops, data[15:14]: 00 STEP, 01 RUN/PAUSE toggle, 10 RF read (addr data[4:0]), 11 MEM read (addr data[MEM_AW-1:0]). data[13]=0 selects bits [15:0] of the read word; 1 selects [31:16].
- States: IDLE, RUN, STEP, RD_ADDR, RD_WAIT, RD_CAP.
- IDLE: cpu_en=0.
  - STEP → STEP.
  - RUN → RUN.
  - Read → RD_ADDR, with resume flag=0.
- RUN: cpu_en=1, running=1.
  - RUN toggle → IDLE.
  - STEP → IDLE. Step while running acts as pause; no extra pulse.
  - Read → RD_ADDR with resume flag=1. cpu_en drops to 0 in the same cycle the state leaves RUN. This is the arbitration rule.
- STEP: cpu_en=1 for exactly one cycle, busy=1, then IDLE.
- RD_ADDR: busy=1. Drive rf_raddr or mem_raddr from cmd_reg. For MEM ops, dbg_mem_sel=1 from this cycle through RD_CAP inclusive.
- RD_WAIT: count LAT cycles (RF_LAT or MEM_LAT). A latency of 0 skips RD_WAIT.
- RD_CAP: result ← selected half of rdata. Next state is RUN if the resume flag is set, else IDLE. dbg_mem_sel=0 on exit.
- MEM read latency (cmd_go → result update) = 2+MEM_LAT cycles. RF read latency = 2+RF_LAT cycles.
- cmd_go while busy (STEP/RD_*) is ignored and dropped, not queued.
- cpu_en and dbg_mem_sel are never 1 in the same cycle.
- Addresses hold their last value after a read. result holds until the next capture or reset.
- Reset mid-read: all outputs return to reset values immediately. The CPU is left paused (IDLE), not resumed.

Test Plan:
- Reset then idle: rst pulse; en=0 for 20 cycles → cpu_en=0, result=16'h0000, running=0, dbg_mem_sel=0 throughout.
- Single step: data=16'h0000, en high 10 cycles → exactly one cycle of cpu_en=1, 3 edges after en rise; no further pulses while en is held.
- Run/pause toggle: data=16'h4000, en pulse → running=1, cpu_en=1 continuously. A second identical pulse → cpu_en=0, running=0.
- RF read: rf model returns {16'hBEEF,16'h0005} at addr 5. data=16'h8005 gives result=16'h0005. data=16'hA005 gives result=16'hBEEF, 2+RF_LAT cycles after cmd_go.
- MEM read while running: RUN active; data=16'hC00A, mem[10]=32'h1234_5678 → cpu_en=0 and dbg_mem_sel=1 for 2+MEM_LAT cycles; result=16'h5678; then cpu_en returns to 1 and dbg_mem_sel=0; the two are never high together.
- Busy drop and async reset: issue a MEM read, and a second en pulse during RD_WAIT → it is ignored and result reflects the first address only. Assert rst during RD_WAIT → outputs are 0 in the same cycle and the state is IDLE after release.
